// File: rtl/player_iter_if.sv
// player_iter_if: valid/ready bus for player_iter; master drives in_* and out_ready, slave drives in_ready/out_valid/out_data
interface player_iter_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_inv;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (
    output in_valid, in_data, in_inv, in_count, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_inv, in_count, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/player_iter.sv
// player_iter: iterated PRESENT pLayer (fwd/inv, in_count passes); ports clk, rst, bus (player_iter_if.slave), abort when PLAYER_ABORT_EN
module player_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  player_iter_if.slave bus
`ifdef PLAYER_ABORT_EN
  , input logic abort
`endif
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, fwd, bwd;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             inv_q, inv_d;
  for (genvar i = 0; i < M; i++) begin : g_p
    assign fwd[(i * (WIDTH / 4)) % M] = data_q[i];
    assign bwd[(4 * i) % M]           = data_q[i];
  end
  assign fwd[M] = data_q[M];
  assign bwd[M] = data_q[M];
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        data_d  = bus.in_data;
        inv_d   = bus.in_inv;
        rem_d   = bus.in_count;
        state_d = bus.in_count != '0 ? RUN : DONE;
      end
      RUN: begin
        data_d  = inv_q ? bwd : fwd;
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == CNT_W'(1) ? DONE : RUN;
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
`ifdef PLAYER_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      data_d  = '0;
      rem_d   = '0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      inv_q   <= inv_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_player_iter.sv
// tb_player_iter: table, random-vs-model and corner sequences for player_iter at WIDTH 64 and 128
module tb_player_iter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  player_iter_if #(.WIDTH(64), .CNT_W(4))  b();
  player_iter_if #(.WIDTH(128), .CNT_W(4)) w();
`ifdef PLAYER_ABORT_EN
  logic abort = 0, abort_w = 0;
`endif
  player_iter #(.WIDTH(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(b)
`ifdef PLAYER_ABORT_EN
    , .abort(abort)
`endif
  );
  player_iter #(.WIDTH(128), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .bus(w)
`ifdef PLAYER_ABORT_EN
    , .abort(abort_w)
`endif
  );
  function automatic logic [127:0] pm(logic [127:0] x, int wd, bit inv, int n);
    logic [127:0] y;
    int m = wd - 1;
    repeat (n) begin
      y = '0;
      for (int i = 0; i < m; i++) y[inv ? (4 * i) % m : (i * (wd / 4)) % m] = x[i];
      y[m] = x[m];
      x = y;
    end
    return x;
  endfunction
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic op64(input logic [63:0] d, input bit inv, input int cnt, output logic [63:0] r, output int lat);
    @(negedge clk);
    chk("in_ready_idle", {127'b0, b.in_ready}, 128'd1);
    b.in_valid = 1; b.in_data = d; b.in_inv = inv; b.in_count = 4'(cnt);
    @(posedge clk);
    #1 b.in_valid = 0; b.in_data = {$urandom, $urandom}; b.in_inv = ~inv; b.in_count = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.out_valid && lat < 40);
    if (!b.out_valid) chk("op_timeout", {127'b0, b.out_valid}, 128'd1);
    r = b.out_data;
    b.out_ready = 1;
    @(posedge clk);
    #1 b.out_ready = 0;
  endtask
  task automatic op128(input logic [127:0] d, input bit inv, input int cnt, output logic [127:0] r);
    int lat;
    @(negedge clk);
    w.in_valid = 1; w.in_data = d; w.in_inv = inv; w.in_count = 4'(cnt);
    @(posedge clk);
    #1 w.in_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!w.out_valid && lat < 40);
    chk("w_latency", 128'(lat), 128'(cnt + 1));
    r = w.out_data;
    w.out_ready = 1;
    @(posedge clk);
    #1 w.out_ready = 0;
  endtask
  typedef struct {
    logic [63:0] d;
    bit          inv;
    int          cnt;
    logic [63:0] exp;
  } vec_t;
  vec_t tv[7];
  initial begin
    logic [63:0]  r, r2, x, bp;
    logic [127:0] q;
    int lat, l2, cnt;
    bit inv;
    tv[0] = '{64'h0000000000000002, 0, 1, 64'h0000000000010000};
    tv[1] = '{64'h8000000000000001, 0, 1, 64'h8000000000000001};
    tv[2] = '{64'h0000000000010000, 1, 1, 64'h0000000000000002};
    tv[3] = '{64'h0123456789ABCDEF, 0, 3, 64'h0123456789ABCDEF};
    tv[4] = '{64'h0123456789ABCDEF, 0, 0, 64'h0123456789ABCDEF};
    tv[5] = '{64'hDEADBEEF01234567, 0, 15, 64'hDEADBEEF01234567};
    tv[6] = '{64'h0000000000000002, 1, 2, 64'h0000000000010000};
    b.in_valid = 0; b.in_data = 0; b.in_inv = 0; b.in_count = 0; b.out_ready = 0;
    w.in_valid = 0; w.in_data = 0; w.in_inv = 0; w.in_count = 0; w.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {127'b0, b.in_ready}, 128'd1);
    chk("rst_out_valid", {127'b0, b.out_valid}, 128'd0);
    chk("rst_out_data", {64'b0, b.out_data}, 128'd0);
    rst = 0;
    foreach (tv[i]) begin
      op64(tv[i].d, tv[i].inv, tv[i].cnt, r, lat);
      chk($sformatf("vec%0d_data", i), {64'b0, r}, {64'b0, tv[i].exp});
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(tv[i].cnt + 1));
    end
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom}; inv = 1'($urandom_range(0, 1)); cnt = $urandom_range(0, 15);
      op64(x, inv, cnt, r, lat);
      chk("rand_data", {64'b0, r}, pm({64'b0, x}, 64, inv, cnt));
      chk("rand_lat", 128'(lat), 128'(cnt + 1));
    end
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      op64(x, 0, 1, r, lat);
      op64(r, 1, 1, r2, l2);
      chk("roundtrip", {64'b0, r2}, {64'b0, x});
    end
    x = 64'h00000000000000F0;
    bp = pm({64'b0, x}, 64, 0, 1);
    @(negedge clk);
    b.in_valid = 1; b.in_data = x; b.in_inv = 0; b.in_count = 1;
    @(posedge clk);
    #1 b.in_data = 64'hFFFF0000FFFF0000; b.in_count = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.out_valid && lat < 40);
    chk("bp_lat", 128'(lat), 128'd2);
    repeat (5) begin
      chk("bp_valid", {127'b0, b.out_valid}, 128'd1);
      chk("bp_in_ready", {127'b0, b.in_ready}, 128'd0);
      chk("bp_data", {64'b0, b.out_data}, {64'b0, bp});
      @(negedge clk);
    end
    b.in_valid = 0; b.out_ready = 1;
    @(posedge clk);
    #1 b.out_ready = 0;
    @(negedge clk);
    chk("bp_release_ready", {127'b0, b.in_ready}, 128'd1);
    chk("bp_release_valid", {127'b0, b.out_valid}, 128'd0);
    @(negedge clk);
    b.in_valid = 1; b.in_data = 64'h0123456789ABCDEF; b.in_inv = 0; b.in_count = 10;
    @(posedge clk);
    #1 b.in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_run_in_ready", {127'b0, b.in_ready}, 128'd1);
    chk("rst_run_out_valid", {127'b0, b.out_valid}, 128'd0);
    chk("rst_run_out_data", {64'b0, b.out_data}, 128'd0);
`ifdef PLAYER_ABORT_EN
    @(negedge clk);
    b.in_valid = 1; b.in_data = 64'h00000000000000FF; b.in_inv = 0; b.in_count = 5;
    @(posedge clk);
    #1 b.in_valid = 0;
    repeat (2) @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    chk("abort_in_ready", {127'b0, b.in_ready}, 128'd1);
    chk("abort_out_valid", {127'b0, b.out_valid}, 128'd0);
    chk("abort_out_data", {64'b0, b.out_data}, 128'd0);
    op64(64'h0000000000000002, 0, 1, r, lat);
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    chk("abort_idle_ready", {127'b0, b.in_ready}, 128'd1);
    chk("abort_idle_data", {64'b0, b.out_data}, 128'h10000);
`endif
    op64(64'h0000000000000002, 0, 2, r, lat);
    chk("post_seq_data", {64'b0, r}, pm(128'h2, 64, 0, 2));
    op128(128'd1 << 1, 0, 1, q);
    chk("w_fwd_bit1", q, 128'd1 << 32);
    op128(128'd1 << 32, 1, 1, q);
    chk("w_inv_bit32", q, 128'd1 << 1);
    op128(128'd1 << 127, 0, 1, q);
    chk("w_fwd_bit127", q, 128'd1 << 127);
    op128(128'd1 << 127, 1, 1, q);
    chk("w_inv_bit127", q, 128'd1 << 127);
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom};
      inv = 1'($urandom_range(0, 1)); cnt = $urandom_range(0, 15);
      op128({x, ~x}, inv, cnt, q);
      chk("w_rand", q, pm({x, ~x}, 128, inv, cnt));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
